// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W[0..63] with K[t].
// Optional W+K adder enabled by defining SHA256_SCHED_WK_SUM_EN.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_round,
    output logic [31:0] out_w,
    output logic [31:0] out_k,
    output logic [31:0] out_wk,
    output logic [6:0]  k_idx,
    input  logic [31:0] k_in,
    output logic        block_done
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [4:0]  lc_reg;
    logic [5:0]  t_reg;
    logic        block_done_reg;
    logic [31:0] sched_buf [16];

    logic        in_fire;
    logic        out_fire;
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [3:0]  idx_m16;
    logic [31:0] w_expand;
    logic [31:0] w_cur;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign in_fire  = in_valid && (state_reg == LOAD);
    assign out_fire = out_ready && (state_reg == RUN);

    // The 16-entry ring holds exactly the window W[t-16..t-1]; 4-bit wrap does the mod 16.
    assign idx_m2  = t_reg[3:0] - 4'd2;
    assign idx_m7  = t_reg[3:0] - 4'd7;
    assign idx_m15 = t_reg[3:0] - 4'd15;
    assign idx_m16 = t_reg[3:0];

    assign w_expand = sigma1(sched_buf[idx_m2]) + sched_buf[idx_m7]
                    + sigma0(sched_buf[idx_m15]) + sched_buf[idx_m16];

    assign w_cur = (t_reg[5:4] == 2'b00) ? sched_buf[t_reg[3:0]] : w_expand;

    // Buffer content is don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            sched_buf[lc_reg[3:0]] <= in_word;
        end else if (out_fire && (t_reg[5:4] != 2'b00)) begin
            sched_buf[t_reg[3:0]] <= w_expand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LOAD;
            lc_reg         <= 5'd0;
            t_reg          <= 6'd0;
            block_done_reg <= 1'b0;
        end else begin
            block_done_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        if (lc_reg == 5'd15) begin
                            state_reg <= RUN;
                            lc_reg    <= 5'd0;
                            t_reg     <= 6'd0;
                        end else begin
                            lc_reg <= lc_reg + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        t_reg <= t_reg + 6'd1;
                        if (t_reg == 6'd63) begin
                            state_reg      <= LOAD;
                            block_done_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign in_ready   = (state_reg == LOAD);
    assign out_valid  = (state_reg == RUN);
    assign out_round  = t_reg;
    assign out_w      = w_cur;
    assign out_k      = k_in;
    assign k_idx      = {1'b0, t_reg};
    assign block_done = block_done_reg;

`ifdef SHA256_SCHED_WK_SUM_EN
    assign out_wk = w_cur + k_in;
`else
    assign out_wk = 32'h0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: array-based reference schedule, random stalls/gaps, resets.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_round;
    logic [31:0] out_w;
    logic [31:0] out_k;
    logic [31:0] out_wk;
    logic [6:0]  k_idx;
    logic [31:0] k_in;
    logic        block_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] k_tab   [64];
    logic [31:0] cur_blk [16];
    logic [31:0] w_model [64];
    logic [31:0] got_w   [64];
    logic [31:0] got_k   [64];
    logic [31:0] got_wk  [64];

    typedef struct {
        int          rnd;
        logic [31:0] w;
        logic [31:0] k;
        logic [31:0] wk;
    } vec_t;
    vec_t vecs [3];

    sha256_msg_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_round  (out_round),
        .out_w      (out_w),
        .out_k      (out_k),
        .out_wk     (out_wk),
        .k_idx      (k_idx),
        .k_in       (k_in),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    // Round-constant lookup is combinational from the index the DUT drives.
    assign k_in = (k_idx < 7'd64) ? k_tab[k_idx[5:0]] : 32'hBAD0BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] exp_wk(input logic [31:0] w, input logic [31:0] k);
`ifdef SHA256_SCHED_WK_SUM_EN
        return w + k;
`else
        return 32'h0 & (w ^ k);
`endif
    endfunction

    task automatic build_model();
        logic [31:0] s0, s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                w_model[i] = cur_blk[i];
            end else begin
                s0 = rotr(w_model[i-15], 7) ^ rotr(w_model[i-15], 18) ^ (w_model[i-15] >> 3);
                s1 = rotr(w_model[i-2], 17) ^ rotr(w_model[i-2], 19) ^ (w_model[i-2] >> 10);
                w_model[i] = s1 + w_model[i-7] + s0 + w_model[i-16];
            end
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        cur_blk[0]  = 32'h61626380;
        cur_blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        build_model();
    endtask

    // Loads cur_blk and drains 64 words; abort_at >= 0 pulses reset when round abort_at is presented.
    task automatic run_block(input int gap_pct, input int stall_pct, input int abort_at);
        int          acc = 0;
        int          cyc = 0;
        int          t = 0;
        bit          stalled = 0;
        logic [31:0] prev_w = 0;
        logic [31:0] prev_k = 0;
        logic [5:0]  prev_r = 0;
        while (acc < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                check("load_timeout", 32'(acc), 32'd16);
                return;
            end
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_word   = in_valid ? cur_blk[acc] : $urandom;
            out_ready = 1'($urandom_range(1));
            #1;
            check("load_out_valid", 32'(out_valid), 32'd0);
            check("load_in_ready", 32'(in_ready), 32'd1);
            if (in_valid && in_ready) acc++;
        end
        cyc = 0;
        while (t < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc > 1000) begin
                check("run_timeout", 32'(t), 32'd64);
                in_valid = 1'b0;
                return;
            end
            in_valid  = 1'b1;
            in_word   = $urandom;
            out_ready = ($urandom_range(99) >= stall_pct);
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_out_valid", 32'(out_valid), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd1);
                check("abort_k_idx", 32'(k_idx), 32'd0);
                check("abort_out_round", 32'(out_round), 32'd0);
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                return;
            end
            #1;
            check("run_out_valid", 32'(out_valid), 32'd1);
            check("run_in_ready", 32'(in_ready), 32'd0);
            if (stalled) begin
                check($sformatf("stall_w r%0d", t), out_w, prev_w);
                check($sformatf("stall_round r%0d", t), 32'(out_round), 32'(prev_r));
                check($sformatf("stall_k r%0d", t), out_k, prev_k);
            end
            check($sformatf("round t%0d", t), 32'(out_round), 32'(t));
            check($sformatf("k_idx t%0d", t), 32'(k_idx), 32'(t));
            check($sformatf("w t%0d", t), out_w, w_model[t]);
            check($sformatf("k t%0d", t), out_k, k_tab[t]);
            check($sformatf("wk t%0d", t), out_wk, exp_wk(w_model[t], k_tab[t]));
            check($sformatf("done_early t%0d", t), 32'(block_done), 32'd0);
            got_w[t]  = out_w;
            got_k[t]  = out_k;
            got_wk[t] = out_wk;
            if (out_ready) begin
                t++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev_w  = out_w;
                prev_k  = out_k;
                prev_r  = out_round;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("done_pulse", 32'(block_done), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_round_wrap", 32'(out_round), 32'd0);
        @(negedge clk);
        #1;
        check("done_single", 32'(block_done), 32'd0);
    endtask

    initial begin
        k_tab = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };

        vecs[0] = '{rnd: 0,  w: 32'h61626380, k: 32'h428a2f98, wk: exp_wk(32'h61626380, 32'h428a2f98)};
        vecs[1] = '{rnd: 16, w: 32'h61626380, k: 32'he49b69c1, wk: exp_wk(32'h61626380, 32'he49b69c1)};
        vecs[2] = '{rnd: 17, w: 32'h000F0000, k: 32'hefbe4786, wk: exp_wk(32'h000F0000, 32'hefbe4786)};
`ifdef SHA256_SCHED_WK_SUM_EN
        check("abc_wk0_const", vecs[0].wk, 32'hA3EC9318);
`endif

        // Reset with in_valid high must not load anything.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_word   = 32'hDEADBEEF;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_round", 32'(out_round), 32'd0);
        check("rst_k_idx", 32'(k_idx), 32'd0);
        check("rst_block_done", 32'(block_done), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        set_abc();
        run_block(0, 0, -1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("vec_w r%0d", vecs[i].rnd), got_w[vecs[i].rnd], vecs[i].w);
            check($sformatf("vec_k r%0d", vecs[i].rnd), got_k[vecs[i].rnd], vecs[i].k);
            check($sformatf("vec_wk r%0d", vecs[i].rnd), got_wk[vecs[i].rnd], vecs[i].wk);
        end

        set_abc();
        run_block(40, 40, -1);

        for (int b = 0; b < 3; b++) begin
            set_random();
            run_block(30, 50, -1);
        end

        set_abc();
        run_block(0, 20, 40);
        set_abc();
        run_block(0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
